// File: rtl/multibank_timing_fsm_pkg.sv
// multibank_timing_fsm_pkg: bank state encoding and default timing constants
package multibank_timing_fsm_pkg;
    typedef enum logic [2:0] {
        BS_IDLE        = 3'd0,
        BS_ACTIVATING  = 3'd1,
        BS_ACTIVE      = 3'd2,
        BS_PRECHARGING = 3'd3,
        BS_REFRESHING  = 3'd4
    } bank_state_t;
    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_CL  = 4;
    localparam int T_RAS = 7;
    localparam int T_WR  = 2;
    localparam int T_RFC = 8;
    localparam int CNT_W = 8;
endpackage

// File: rtl/multibank_timing_fsm_bank_fsm.sv
// bank_fsm: one bank's state, open row and timing counters; strobes arrive pre-qualified
module bank_fsm import multibank_timing_fsm_pkg::*; #(
    parameter int RW   = 17,
    parameter int TRCD = T_RCD,
    parameter int TRP  = T_RP,
    parameter int TRAS = T_RAS,
    parameter int TWR  = T_WR,
    parameter int TRFC = T_RFC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          act,
    input  logic          wr,
    input  logic          pr,
    input  logic          refresh,
    input  logic [RW-1:0] row_in,
    output bank_state_t   state,
    output logic [RW-1:0] open_row,
    output logic          ready
);
    logic [CNT_W-1:0] cnt, tras, twr;

    assign ready = (tras == '0) && (twr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BS_IDLE;
            cnt      <= '0;
            tras     <= '0;
            twr      <= '0;
            open_row <= '0;
        end else if (!halt) begin
            tras <= (tras != '0) ? tras - 1'b1 : '0;
            twr  <= (twr != '0) ? twr - 1'b1 : '0;
            if (act) begin
                state    <= BS_ACTIVATING;
                cnt      <= CNT_W'(TRCD);
                tras     <= CNT_W'(TRAS);
                open_row <= row_in;
            end else if (wr) begin
                twr <= CNT_W'(TWR);
            end else if (pr) begin
                state <= BS_PRECHARGING;
                cnt   <= CNT_W'(TRP);
            end else if (refresh) begin
                state <= BS_REFRESHING;
                cnt   <= CNT_W'(TRFC);
            end else if (state inside {BS_ACTIVATING, BS_PRECHARGING, BS_REFRESHING}) begin
                // leave the timed state on the edge that ends its last cycle
                cnt <= (cnt > 1) ? cnt - 1'b1 : '0;
                if (cnt <= 1)
                    state <= (state == BS_ACTIVATING) ? BS_ACTIVE : BS_IDLE;
            end
        end
    end
endmodule

// File: rtl/multibank_timing_fsm.sv
// multibank_timing_fsm: command decode/legality, read-latency pipeline and per-bank FSMs
module multibank_timing_fsm import multibank_timing_fsm_pkg::*; #(
    parameter int NBANKS = 4,
    parameter int ROWS   = 131072,
    parameter int COLS   = 1024,
    parameter int TRCD   = T_RCD,
    parameter int TRP    = T_RP,
    parameter int TCL    = T_CL,
    parameter int TRAS   = T_RAS,
    parameter int TWR    = T_WR,
    parameter int TRFC   = T_RFC,
    localparam int BW    = $clog2(NBANKS),
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   ACT,
    input  logic                   RD,
    input  logic                   WR,
    input  logic                   PR,
    input  logic                   PRA,
    input  logic                   REF,
    input  logic [BW-1:0]          bank,
    input  logic [RW-1:0]          row,
    input  logic [CW-1:0]          column,
    output logic [3*NBANKS-1:0]    bank_state,
    output logic [RW*NBANKS-1:0]   open_row,
    output logic                   rd_valid,
    output logic [BW-1:0]          rd_bank,
    output logic [CW-1:0]          rd_col,
    output logic                   err
);
    localparam int PW = 1 + BW + CW;
    localparam int PD = (TCL > 1) ? TCL - 1 : 1;

    bank_state_t st [NBANKS];
    logic [NBANKS-1:0] idle, active, ready, pr_ok;
    logic [5:0] strobes;
    logic legal, go;
    logic [PW-1:0] rd_in, tap;
    logic [PW-1:0] pipe [PD];

    assign strobes = {ACT, RD, WR, PR, PRA, REF};
    assign pr_ok   = idle | (active & ready);
    assign legal   = (ACT && idle[bank]) || ((RD || WR) && active[bank]) ||
                     (PR && pr_ok[bank]) || (PRA && (&pr_ok)) || (REF && (&idle));
    assign go      = !halt && $onehot(strobes) && legal;
    assign rd_in   = {go && RD, bank, column};
    // pipe holds TCL-1 stages; the output register supplies the last cycle of latency
    assign tap     = (TCL > 1) ? pipe[PD-1] : rd_in;

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        assign idle[i]   = st[i] == BS_IDLE;
        assign active[i] = st[i] == BS_ACTIVE;
        assign bank_state[3*i +: 3] = st[i];
        bank_fsm #(.RW(RW), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TWR(TWR), .TRFC(TRFC)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .halt     (halt),
            .act      (go && ACT && bank == BW'(i)),
            .wr       (go && WR && bank == BW'(i)),
            .pr       (go && active[i] && (PRA || (PR && bank == BW'(i)))),
            .refresh  (go && REF),
            .row_in   (row),
            .state    (st[i]),
            .open_row (open_row[RW*i +: RW]),
            .ready    (ready[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PD; k++) pipe[k] <= '0;
            {rd_valid, rd_bank, rd_col} <= '0;
            err <= 1'b0;
        end else if (halt) begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            pipe[0] <= rd_in;
            for (int k = 1; k < PD; k++) pipe[k] <= pipe[k-1];
            {rd_valid, rd_bank, rd_col} <= tap;
            err <= (|strobes) && !go;
        end
    end
endmodule

// File: tb/tb_multibank_timing_fsm.sv
// tb_multibank_timing_fsm: directed vectors with hand-computed expectations
module tb_multibank_timing_fsm;
    import multibank_timing_fsm_pkg::*;

    localparam logic [5:0] S_ACT = 6'b100000, S_RD = 6'b010000, S_WR = 6'b001000;
    localparam logic [5:0] S_PR = 6'b000100, S_PRA = 6'b000010, S_REF = 6'b000001;
    localparam logic [2:0] I = BS_IDLE, AG = BS_ACTIVATING, A = BS_ACTIVE;
    localparam logic [2:0] P = BS_PRECHARGING, R = BS_REFRESHING;

    logic clk = 1'b0;
    logic rst, halt, ACT, RD, WR, PR, PRA, REF;
    logic [1:0] bank;
    logic [16:0] row;
    logic [9:0] column;
    logic [11:0] bank_state;
    logic [67:0] open_row;
    logic rd_valid, err;
    logic [1:0] rd_bank;
    logic [9:0] rd_col;
    int errors = 0, checks = 0;

    multibank_timing_fsm dut (
        .clk(clk), .rst(rst), .halt(halt), .ACT(ACT), .RD(RD), .WR(WR), .PR(PR),
        .PRA(PRA), .REF(REF), .bank(bank), .row(row), .column(column),
        .bank_state(bank_state), .open_row(open_row), .rd_valid(rd_valid),
        .rd_bank(rd_bank), .rd_col(rd_col), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bs(input logic [2:0] b3, b2, b1, b0);
        return {b3, b2, b1, b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [5:0] s, input int b, input int r, input int c);
        {ACT, RD, WR, PR, PRA, REF} = s;
        bank = 2'(b);
        row = 17'(r);
        column = 10'(c);
        tick;
        {ACT, RD, WR, PR, PRA, REF} = 6'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b1; {ACT, RD, WR, PR, PRA, REF} = S_ACT;
        bank = 2'd0; row = 17'd5; column = 10'd0;
        tick; tick;
        rst = 1'b0; halt = 1'b0; {ACT, RD, WR, PR, PRA, REF} = 6'b0;
        check("rst_state", bank_state, 0);
        check("rst_row", open_row, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_err", err, 0);
        check("rst_tags", {rd_bank, rd_col}, 0);

        // ACT bank0 row5: ACTIVATING three cycles, then ACTIVE
        cmd(S_ACT, 0, 5, 0);
        check("act_c1", bank_state, bs(I, I, I, AG));
        check("act_row", open_row[16:0], 5);
        tick; check("act_c2", bank_state, bs(I, I, I, AG));
        tick; check("act_c3", bank_state, bs(I, I, I, AG));
        tick; check("act_c4", bank_state, bs(I, I, I, A));

        // back-to-back reads, TCL=4
        cmd(S_RD, 0, 0, 7);
        cmd(S_RD, 0, 0, 9);
        check("rd_err", err, 0);
        tick; check("rd_early", rd_valid, 0);
        tick; check("rd1_v", rd_valid, 1); check("rd1_tag", {rd_bank, rd_col}, {2'd0, 10'd7});
        tick; check("rd2_v", rd_valid, 1); check("rd2_tag", {rd_bank, rd_col}, {2'd0, 10'd9});
        tick; check("rd_done", rd_valid, 0);

        // read to an idle bank
        cmd(S_RD, 1, 0, 4);
        check("rd_idle_err", err, 1);
        check("rd_idle_st", bank_state, bs(I, I, I, A));
        tick; check("rd_idle_pulse", err, 0);
        for (int k = 0; k < 5; k++) begin
            tick; check("rd_idle_nov", rd_valid, 0);
        end

        // tWR blocks precharge
        cmd(S_WR, 0, 0, 1);
        check("wr_err", err, 0);
        cmd(S_PR, 0, 0, 0);
        check("pr_twr_err", err, 1);
        check("pr_twr_st", bank_state, bs(I, I, I, A));
        tick;
        cmd(S_PR, 0, 0, 0);
        check("pr_ok_err", err, 0);
        check("pr_p1", bank_state, bs(I, I, I, P));
        tick; check("pr_p2", bank_state, bs(I, I, I, P));
        tick; check("pr_p3", bank_state, bs(I, I, I, P));
        tick; check("pr_idle", bank_state, 0);

        // halt for three cycles during ACTIVATING
        cmd(S_ACT, 0, 9, 0);
        check("h_c1", bank_state, bs(I, I, I, AG));
        check("h_row", open_row[16:0], 9);
        halt = 1'b1; {ACT, RD, WR, PR, PRA, REF} = S_RD; bank = 2'd2;
        tick; check("h_err", err, 0);
        tick; tick;
        halt = 1'b0; {ACT, RD, WR, PR, PRA, REF} = 6'b0;
        check("h_c4", bank_state, bs(I, I, I, AG));
        check("h_err4", err, 0);
        tick; tick; check("h_c6", bank_state, bs(I, I, I, AG));
        tick; check("h_c7", bank_state, bs(I, I, I, A));

        // PR two cycles after ACTIVE is blocked by tRAS
        tick; tick;
        cmd(S_PR, 0, 0, 0);
        check("pr_tras_err", err, 1);
        check("pr_tras_st", bank_state, bs(I, I, I, A));
        tick;
        cmd(S_PR, 0, 0, 0);
        check("pr2_err", err, 0);
        check("pr2_p", bank_state, bs(I, I, I, P));
        tick; tick; tick; check("pr2_idle", bank_state, 0);

        // REF/PRA aggregation with bank2 open
        cmd(S_ACT, 2, 3, 0);
        tick; tick; tick;
        check("b2_active", bank_state, bs(I, A, I, I));
        check("b2_row", open_row[50:34], 3);
        cmd(S_RD, 2, 0, 3);
        check("b2_rd_err", err, 0);
        cmd(S_REF, 0, 0, 0);
        check("ref_err", err, 1);
        check("ref_err_st", bank_state, bs(I, A, I, I));
        cmd(S_PRA, 0, 0, 0);
        check("pra_err", err, 1);
        tick;
        check("b2_rd_v", rd_valid, 1);
        check("b2_rd_tag", {rd_bank, rd_col}, {2'd2, 10'd3});
        cmd(S_PRA, 0, 0, 0);
        check("pra_ok_err", err, 0);
        check("pra_p", bank_state, bs(I, P, I, I));
        tick; tick; tick; check("pra_idle", bank_state, 0);
        cmd(S_REF, 0, 0, 0);
        check("ref_ok_err", err, 0);
        check("ref_r1", bank_state, bs(R, R, R, R));
        cmd(S_ACT, 1, 1, 0);
        check("ref_act_err", err, 1);
        for (int k = 0; k < 6; k++) tick;
        check("ref_r8", bank_state, bs(R, R, R, R));
        tick; check("ref_idle", bank_state, 0);

        // conflicting strobes
        cmd(S_RD | S_WR, 0, 0, 0);
        check("rdwr_err", err, 1);
        cmd(S_ACT | S_PR, 0, 0, 0);
        check("actpr_err", err, 1);
        check("multi_st", bank_state, 0);

        // reset drops an in-flight read
        cmd(S_ACT, 1, 7, 0);
        tick; tick; tick;
        check("b1_active", bank_state, bs(I, I, A, I));
        cmd(S_RD, 1, 0, 5);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_st", bank_state, 0);
        check("mid_rst_row", open_row, 0);
        for (int k = 0; k < 6; k++) begin
            tick; check("mid_rst_nov", rd_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multibank_timing_fsm.md
MULTIBANK_TIMING_FSM -- requirements
Module: multibank_timing_fsm

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NBANKS, 4, bank count; ROWS, 131072, rows per bank; COLS, 1024, columns per bank.
REQ-002 Timing parameters SHALL be in clk cycles, each >=1: TRCD 3, TRP 3, TCL 4, TRAS 7, TWR 2, TRFC 8.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 halt  in  1  freezes all counters and the read pipeline; commands ignored.
REQ-006 ACT, RD, WR, PR, PRA, REF  in  1 each  command strobes, one-cycle pulses.
REQ-007 bank  in  $clog2(NBANKS)  target bank for ACT/RD/WR/PR.
REQ-008 row  in  $clog2(ROWS)  row for ACT; column  in  $clog2(COLS)  column for RD/WR.
REQ-009 bank_state  out  3*NBANKS  packed per-bank state, bank 0 in LSBs.
REQ-010 open_row  out  $clog2(ROWS)*NBANKS  latched row per bank.
REQ-011 rd_valid  out  1  read data slot strobe; rd_bank, rd_col  out  bank/column widths  tags for that slot.
REQ-012 err  out  1  one-cycle pulse on illegal or conflicting command.

Function
REQ-013 Per-bank states SHALL be IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING.
REQ-014 ACT to an IDLE bank SHALL latch row into open_row, enter ACTIVATING for TRCD cycles, then ACTIVE; tRAS counter loads TRAS on the same edge.
REQ-015 RD/WR SHALL be legal only when the target bank is ACTIVE.
REQ-016 A legal RD SHALL produce rd_valid exactly TCL cycles later with rd_bank/rd_col of that RD; back-to-back RDs SHALL pipeline without loss.
REQ-017 A legal WR SHALL load that bank's tWR counter with TWR.
REQ-018 PR SHALL be legal only on an ACTIVE bank with tRAS and tWR counters at 0: enter PRECHARGING for TRP cycles, then IDLE.
REQ-019 PR to an IDLE bank SHALL be a legal no-op.
REQ-020 PRA SHALL apply REQ-018/REQ-019 to every bank and be legal only if each bank qualifies; else err and no bank changes.
REQ-021 REF SHALL be legal only when all banks are IDLE: all banks enter REFRESHING for TRFC cycles, then IDLE.
REQ-022 Any illegal command SHALL pulse err the next cycle and leave all state unchanged.
REQ-023 More than one strobe high in a cycle SHALL be treated as illegal: err, all ignored.
REQ-024 While halt=1, counters, the read pipeline and states SHALL hold; strobes SHALL be ignored without err; rd_valid SHALL be 0.
REQ-025 Counters SHALL saturate at 0 and never wrap.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst SHALL set all banks IDLE, open_row 0, all counters 0, the read pipeline empty, and rd_valid, rd_bank, rd_col, err to 0.
REQ-028 rst SHALL override halt and any concurrent strobe.
REQ-029 rst mid-operation SHALL drop in-flight reads with no rd_valid afterwards.

Structure
REQ-030 A shared package SHALL hold the bank_state enum (3-bit encoding) and the default timing constants.
REQ-031 Per-bank state and counters SHALL live in sub-module bank_fsm, instantiated NBANKS times.
REQ-032 Command decode and legality, the TCL read pipeline, and REF/PRA aggregation SHALL live in the top.

Verification
REQ-033 ACT bank0 row5 at cycle 0 -> bank0 ACTIVATING cycles 1-3, ACTIVE at cycle 4, open_row[0]=5.
REQ-034 RD bank0 col7 and RD bank0 col9 on consecutive cycles while ACTIVE -> rd_valid high on two consecutive cycles, TCL=4 after each RD, tags 0/7 then 0/9.
REQ-035 RD to IDLE bank1 -> err for one cycle, all bank_state unchanged, no rd_valid.
REQ-036 halt high 3 cycles during ACTIVATING -> ACTIVE reached at cycle 7 instead of 4.
REQ-037 PR bank0 2 cycles after ACTIVE -> err; PR after TRAS elapsed -> PRECHARGING 3 cycles, then IDLE.
REQ-038 REF with bank2 ACTIVE -> err; REF with all banks IDLE -> all REFRESHING 8 cycles, then IDLE; simultaneous RD+WR -> err.
